// File: rtl/spectrum_accum_ctrl_if.sv
// Stream bundle for spectrum_accum_ctrl.
// Carries the bin-power input stream and the averaged output stream.
interface spectrum_accum_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_bits;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_bits;

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits
  );

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits
  );
endinterface

// File: rtl/spectrum_accum_ctrl.sv
// Spectrum frame averager: accumulates 2^cfg_avg_log2 frames in SRAM, then
// streams bin averages. Macro SPECTRUM_ACCUM_SATURATE_EN clamps sums.
module spectrum_accum_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        cfg_avg_log2,
  spectrum_accum_ctrl_if.slave s,
  output logic              busy,
  output logic              done,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DUMP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = '1;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_avg;
  logic [ADDR_W-1:0] r_bin;
  logic [7:0]        r_frame;
  logic              r_wr_en;
  logic              r_wr_acc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_bits;

  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_all;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_out_cnt;

  logic              w_acc;
  logic              w_last_bin;
  logic              w_last_frame;
  logic [7:0]        w_frames_m1;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_done;
  logic              w_run;
  logic [DATA_W-1:0] w_acc_word;

  assign w_run        = (r_state == S_IDLE) && start;
  assign w_acc        = s.in_valid && (r_state == S_ACCUM);
  assign w_last_bin   = (r_bin == LAST_BIN);
  assign w_frames_m1  = (8'd1 << r_avg) - 8'd1;
  assign w_last_frame = (r_frame == w_frames_m1);
  assign w_pop        = (r_cnt != 2'd0) && s.out_ready;
  // Count the pop of this cycle so a full-rate drain can keep issuing.
  assign w_occ        = {1'b0, r_cnt} + {2'b0, r_rd_pend}
                      - {2'b0, w_pop};
  assign w_issue      = (r_state == S_DUMP) && !r_rd_all
                      && (w_occ < 3'd2);
  assign w_done       = w_pop && (r_out_cnt == LAST_BIN);

`ifdef SPECTRUM_ACCUM_SATURATE_EN
  logic [DATA_W:0] w_sum;
  assign w_sum      = {1'b0, mem_R0_data} + {1'b0, r_wr_bits};
  assign w_acc_word = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
  assign w_acc_word = mem_R0_data + r_wr_bits;
`endif

  assign mem_W0_en   = r_wr_en;
  assign mem_W0_addr = r_wr_addr;
  assign mem_W0_data = r_wr_acc ? w_acc_word : r_wr_bits;
  assign s.out_valid = (r_cnt != 2'd0);
  assign s.out_bits  = r_buf[r_rp];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and control outputs.
  always_comb begin
    w_next      = r_state;
    s.in_ready  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    mem_R0_en   = 1'b0;
    mem_R0_addr = r_bin;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        s.in_ready = 1'b1;
        mem_R0_en  = w_acc && (r_frame != 8'd0);
        if (w_acc && w_last_bin && w_last_frame)
          w_next = S_DUMP;
      end
      S_DUMP: begin
        done        = w_done;
        mem_R0_en   = w_issue;
        mem_R0_addr = r_rd_addr;
        if (w_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulate path: counters and the one-cycle write pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_avg     <= '0;
      r_bin     <= '0;
      r_frame   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_acc  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_bits <= '0;
    end else begin
      r_wr_en <= w_acc;
      if (w_acc) begin
        r_wr_addr <= r_bin;
        r_wr_bits <= s.in_bits;
        r_wr_acc  <= (r_frame != 8'd0);
        r_bin     <= r_bin + 1'b1;
        if (w_last_bin) r_frame <= r_frame + 8'd1;
      end
      if (w_run) begin
        r_avg   <= cfg_avg_log2;
        r_bin   <= '0;
        r_frame <= '0;
      end
    end
  end

  // Dump path: read issue, in-flight tracking and 2-entry output buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_all  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_out_cnt <= '0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        if (r_rd_addr == LAST_BIN) r_rd_all <= 1'b1;
      end
      if (r_rd_pend) begin
        r_buf[r_wp] <= mem_R0_data >> r_avg;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp      <= ~r_rp;
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      r_cnt <= r_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
      if (w_run) begin
        r_rd_addr <= '0;
        r_rd_all  <= 1'b0;
        r_out_cnt <= '0;
        r_wp      <= 1'b0;
        r_rp      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_accum_ctrl.sv
// Randomized scoreboard bench for spectrum_accum_ctrl (ADDR_W=2).
// Reference model averages frames with plain arithmetic.
module tb_spectrum_accum_ctrl;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int NB = 1 << AW;

  logic          clk = 0;
  logic          reset;
  logic          start;
  logic [2:0]    cfg;
  logic          busy, done;
  logic          r_en, w_en;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_data, w_data;

  spectrum_accum_ctrl_if #(.DATA_W(DW)) bus ();

  spectrum_accum_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clk), .reset(reset), .start(start),
    .cfg_avg_log2(cfg), .s(bus), .busy(busy), .done(done),
    .mem_R0_en(r_en), .mem_R0_addr(r_addr),
    .mem_R0_data(r_data), .mem_W0_en(w_en),
    .mem_W0_addr(w_addr), .mem_W0_data(w_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM model with one-cycle read latency.
  logic [DW-1:0] mem [NB];
  always @(posedge clk) begin
    if (r_en && w_en) chk("rw_same_addr", {31'd0, r_addr == w_addr}, 0);
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } exp_t;
  exp_t sb[$];

  // out_ready driver: 0 always high, 1 pattern 1,0,0,1, 2 random.
  int rdy_mode = 0;
  int ph = 0;
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        2: bus.out_ready = $urandom_range(0, 1);
        default: bus.out_ready = 1;
      endcase
    end
  end

  // Monitor: pops expected beats and checks ordering, done and stalls.
  bit            prev_stall = 0;
  logic [DW-1:0] prev_bits;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", {31'd0, bus.out_valid}, 1);
          chk("stall_bits", bus.out_bits, prev_bits);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", bus.out_bits, 'x);
          end else begin
            e = sb.pop_front();
            chk("out_bits", bus.out_bits, e.d);
            chk("done", {31'd0, done}, {31'd0, e.last});
          end
        end else if (done) begin
          chk("done_no_pop", {31'd0, done}, 0);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_bits  = bus.out_bits;
      end
    end
  end

  logic [DW-1:0] stim [128][NB];

  function automatic logic [DW-1:0] add(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW:0] t;
    t = {1'b0, a} + {1'b0, b};
`ifdef SPECTRUM_ACCUM_SATURATE_EN
    return t[DW] ? '1 : t[DW-1:0];
`else
    return t[DW-1:0];
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [DW-1:0] d, input int gapmax);
    int n = 0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1;
    bus.in_bits  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    start = 0;
  endtask

  task automatic pulse_start(input int avg);
    cfg   = avg[2:0];
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    chk("start_latency", {31'd0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 0);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int avg, input int gapmax, input bit poke);
    int nf;
    logic [DW-1:0] acc;
    nf = 1 << avg;
    pulse_start(avg);
    if (poke) cfg = 3'(avg + 1 + $urandom_range(0, 5));
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < NB; k++) begin
        if (poke && f == 0 && k == 1) start = 1;
        send(stim[f][k], gapmax);
      end
    for (int k = 0; k < NB; k++) begin
      acc = stim[0][k];
      for (int f = 1; f < nf; f++) acc = add(acc, stim[f][k]);
      sb.push_back('{acc >> avg, k == NB - 1});
    end
    if (poke) begin
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    wait_idle();
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < NB; i++) mem[i] = $urandom;
    reset = 1;
    start = 0;
    cfg = 0;
    bus.in_valid = 0;
    bus.in_bits = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_r_en", {31'd0, r_en}, 0);
    chk("rst_w_en", {31'd0, w_en}, 0);
    @(posedge clk);
    #1;

    // Single frame, continuous input.
    for (int k = 0; k < NB; k++) stim[0][k] = 5 + k;
    run(0, 0, 0);

    // Four frames averaged, random gaps.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < NB; k++) stim[f][k] = 4 * (k + 1);
    run(2, 3, 0);

    // Output stall pattern.
    rdy_mode = 1;
    ph = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < NB; k++) stim[f][k] = $urandom_range(0, 1000);
    run(1, 0, 0);
    rdy_mode = 0;

    // Overflow at bin 0.
    for (int k = 0; k < NB; k++) begin
      stim[0][k] = $urandom_range(0, 100);
      stim[1][k] = $urandom_range(0, 100);
    end
    stim[0][0] = 32'hFFFF_FFF0;
    stim[1][0] = 32'h20;
    run(1, 1, 0);

    // Abort mid frame 1, then a fresh run.
    pulse_start(1);
    for (int k = 0; k < NB; k++) send(32'h100 + k, 0);
    send(32'h200, 0);
    send(32'h201, 0);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 0);
    chk("abort_w_en", {31'd0, w_en}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) stim[0][k] = 3;
    run(0, 0, 0);

    // Start pokes and cfg changes mid-run, randomized traffic.
    for (int r = 0; r < 6; r++) begin
      int avg;
      avg = (r == 5) ? 7 : $urandom_range(0, 4);
      rdy_mode = 2;
      for (int f = 0; f < (1 << avg); f++)
        for (int k = 0; k < NB; k++) begin
          v = $urandom;
          stim[f][k] = (r % 2 == 0) ? v : (v >> 4);
        end
      run(avg, (avg > 4) ? 0 : 2, 1);
    end
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spectrum_accum_ctrl.md
SPECTRUM_ACCUM_CTRL -- requirements
Module: spectrum_accum_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM address width; frame length is 2^ADDR_W bins.
REQ-002 Parameter DATA_W, default 32, sample, accumulator and SRAM word width.
REQ-003 Ports: clock  in  1  single clock for all logic and both SRAM ports.
REQ-004 Ports: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: start  in  1  one-cycle pulse; begins averaging run when idle.
REQ-006 Ports: cfg_avg_log2  in  3  frames to average = 2^cfg_avg_log2 (1..128).
REQ-007 Ports: in_valid / in_ready / in_bits  in / out / DATA_W  unsigned bin-power input stream, bin order 0..2^ADDR_W-1.
REQ-008 Ports: out_valid / out_ready / out_bits  out / in / DATA_W  averaged spectrum output stream, bin order.
REQ-009 Ports: busy  out  1  high outside IDLE.
REQ-010 Ports: done  out  1  one-cycle pulse on acceptance of last output bin.
REQ-011 Ports: mem_R0_en, mem_R0_addr  out  1, ADDR_W  SRAM read port request.
REQ-012 Ports: mem_R0_data  in  DATA_W  SRAM read data, valid exactly one cycle after mem_R0_en.
REQ-013 Ports: mem_W0_en, mem_W0_addr, mem_W0_data  out  1, ADDR_W, DATA_W  SRAM write port.

Function
REQ-014 States SHALL be IDLE, ACCUM, DUMP; IDLE->ACCUM on start; ACCUM->DUMP after last bin of last frame is written; DUMP->IDLE when done pulses.
REQ-015 start in ACCUM or DUMP SHALL be ignored; cfg_avg_log2 SHALL be latched on start and held for the run.
REQ-016 in_ready SHALL be 1 only in ACCUM; an input beat is accepted when in_valid && in_ready.
REQ-017 Accepted beat at bin k (cycle T): mem_R0_en=1, mem_R0_addr=k in T; bits registered.
REQ-018 Cycle T+1: mem_W0_en=1, mem_W0_addr=k, mem_W0_data = bits (frame 0) or mem_R0_data+bits (frames 1..N-1); read is suppressed in frame 0.
REQ-019 Bin counter SHALL wrap from 2^ADDR_W-1 to 0 and increment frame counter; input gaps SHALL not affect counting.
REQ-020 Read and write to the same address SHALL never occur in one cycle (consecutive addresses differ by construction; ADDR_W>=1).
REQ-021 DUMP SHALL read bins 0..2^ADDR_W-1 in order; out_bits = stored word >> latched cfg_avg_log2 (logical shift).
REQ-022 DUMP output SHALL use a 2-entry buffer; a read is issued only when buffered+in-flight < 2; out_ready low SHALL stall without loss or duplication.
REQ-023 Sustained throughput SHALL be one beat/cycle in ACCUM and in DUMP with out_ready held high.
REQ-024 Latency from start to first in_ready=1 SHALL be one cycle; from the final ACCUM write to first out_valid SHALL be at most three cycles.
REQ-025 mem_W0_en SHALL be 0 in DUMP and IDLE except the final ACCUM write completing on the ACCUM->DUMP transition cycle.

Reset
REQ-026 Reset SHALL force IDLE, clear bin/frame/read counters and output buffer; in_ready, out_valid, busy, done, mem_R0_en, mem_W0_en SHALL be 0; in-flight reads discarded.
REQ-027 Reset mid-run SHALL abandon stored data; next run's frame 0 overwrites SRAM, no clearing pass is required.

Configuration
REQ-028 Macro SPECTRUM_ACCUM_SATURATE_EN defined: accumulation sum exceeding 2^DATA_W-1 SHALL clamp to 2^DATA_W-1.
REQ-029 Macro SPECTRUM_ACCUM_SATURATE_EN undefined: sum SHALL wrap modulo 2^DATA_W.

Verification
REQ-030 ADDR_W=2, cfg_avg_log2=0, inputs 5,6,7,8 continuous -> outputs 5,6,7,8, done on fourth beat.
REQ-031 ADDR_W=2, cfg_avg_log2=2, every frame 4,8,12,16 with random in_valid gaps -> outputs 4,8,12,16.
REQ-032 DUMP with out_ready toggling 1,0,0,1 pattern -> every bin emitted exactly once, in order, out_bits stable while stalled.
REQ-033 Two frames of 0xFFFF_FFF0 then 0x20 at bin 0, cfg_avg_log2=1 -> with macro 0x7FFF_FFFF, without macro 0x8.
REQ-034 Reset asserted mid-frame 1, then new run with inputs all 3, cfg_avg_log2=0 -> all outputs 3, no stale data.
REQ-035 start pulsed during ACCUM and DUMP -> ignored; cfg_avg_log2 changed mid-run -> shift uses latched value.
